// File: rtl/sign_deduction_pipe_pkg.sv
// Shared types and constants for the pipelined sign/magnitude offset stage.
// The result record is sized for the default coordinate width and channel count.
package sign_deduction_pipe_pkg;

  localparam int SD_WIDTH    = 12;
  localparam int SD_CHANNELS = 2;
  localparam int CLAMP_OFF   = 0;

  function automatic int chan_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  localparam int SD_CW = chan_width(SD_CHANNELS);

  typedef struct packed {
    logic [SD_CW-1:0]    chan;
    logic [SD_WIDTH-1:0] mag;
    logic                sign;
    logic                zero;
    logic                clamped;
  } sd_result_t;

endpackage

// File: rtl/sign_deduction_pipe_if.sv
// Sample/result handshake bundle between coordinate producers and the sign/magnitude pipe.
interface sign_deduction_pipe_if
  import sign_deduction_pipe_pkg::*;
#(
  parameter int WIDTH = SD_WIDTH,
  parameter int CW    = SD_CW
);
  logic             in_valid;
  logic             in_ready;
  logic [CW-1:0]    in_chan;
  logic [WIDTH-1:0] in_coord;
  logic             in_cal;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_chan;
  logic [WIDTH-1:0] out_mag;
  logic             out_sign;
  logic             out_zero;
  logic             out_clamped;

  modport master (
    output in_valid, in_chan, in_coord, in_cal, out_ready,
    input  in_ready, out_valid, out_chan, out_mag, out_sign, out_zero, out_clamped
  );

  modport slave (
    input  in_valid, in_chan, in_coord, in_cal, out_ready,
    output in_ready, out_valid, out_chan, out_mag, out_sign, out_zero, out_clamped
  );
endinterface

// File: rtl/sign_deduction_pipe_sign_mag_core.sv
// Combinational second stage: absolute difference from the captured sign, then optional saturation.
module sign_mag_core
  import sign_deduction_pipe_pkg::*;
#(
  parameter int WIDTH = SD_WIDTH,
  parameter int CLAMP = CLAMP_OFF
) (
  input  logic [WIDTH-1:0] coord,
  input  logic [WIDTH-1:0] offset,
  input  logic             sign,
  output logic [WIDTH-1:0] mag,
  output logic             clamped
);
  localparam logic [WIDTH-1:0] CLAMP_V = WIDTH'(CLAMP);

  logic [WIDTH-1:0] diff_s;

  // Subtracting the smaller operand from the larger keeps the result exact in WIDTH bits.
  always_comb begin
    if (sign) begin
      diff_s = offset - coord;
    end else begin
      diff_s = coord - offset;
    end
    if ((CLAMP != CLAMP_OFF) && (diff_s > CLAMP_V)) begin
      mag     = CLAMP_V;
      clamped = 1'b1;
    end else begin
      mag     = diff_s;
      clamped = 1'b0;
    end
  end
endmodule

// File: rtl/sign_deduction_pipe.sv
// Multi-channel offset subtractor: per-channel offsets, in-band calibration and a
// two-stage elastic valid/ready pipeline producing |coord - offset| with flags.
module sign_deduction_pipe
  import sign_deduction_pipe_pkg::*;
#(
  parameter int  WIDTH    = SD_WIDTH,
  parameter int  CHANNELS = SD_CHANNELS,
  parameter int  CLAMP    = CLAMP_OFF,
  localparam int CW       = chan_width(CHANNELS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 off_we,
  input  logic [CW-1:0]        off_sel,
  input  logic [WIDTH-1:0]     off_data,
  sign_deduction_pipe_if.slave bus
);
  logic [WIDTH-1:0] off_r [CHANNELS];

  logic             s1_valid_r;
  logic [CW-1:0]    s1_chan_r;
  logic [WIDTH-1:0] s1_coord_r;
  logic [WIDTH-1:0] s1_off_r;
  logic             s1_sign_r;
  logic             s1_zero_r;
  logic             s2_valid_r;
  sd_result_t       out_r;

  logic             s2_free_s;
  logic             in_ready_s;
  logic             accept_s;
  logic [WIDTH-1:0] off_rd_s;
  logic [WIDTH-1:0] mag_s;
  logic             clamped_s;

  assign s2_free_s  = !s2_valid_r || bus.out_ready;
  assign in_ready_s = !s1_valid_r || s2_free_s;
  assign accept_s   = bus.in_valid && in_ready_s;

  // Offset lookup for the incoming sample; indices with no register read as zero.
  always_comb begin
    off_rd_s = {WIDTH{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      off_rd_s = (bus.in_chan == CW'(i)) ? off_r[i] : off_rd_s;
    end
  end

  // Offset register file: a direct write beats a calibration hit on the same channel.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (rst) begin
        off_r[i] <= {WIDTH{1'b0}};
      end else if (off_we && (off_sel == CW'(i))) begin
        off_r[i] <= off_data;
      end else if (accept_s && bus.in_cal && (bus.in_chan == CW'(i))) begin
        off_r[i] <= bus.in_coord;
      end
    end
  end

  sign_mag_core #(
    .WIDTH (WIDTH),
    .CLAMP (CLAMP)
  ) u_core (
    .coord   (s1_coord_r),
    .offset  (s1_off_r),
    .sign    (s1_sign_r),
    .mag     (mag_s),
    .clamped (clamped_s)
  );

  // Elastic pipeline: each stage loads whenever its downstream slot is empty or draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_chan_r  <= {CW{1'b0}};
      s1_coord_r <= {WIDTH{1'b0}};
      s1_off_r   <= {WIDTH{1'b0}};
      s1_sign_r  <= 1'b0;
      s1_zero_r  <= 1'b0;
      s2_valid_r <= 1'b0;
      out_r      <= {$bits(sd_result_t){1'b0}};
    end else begin
      if (in_ready_s) begin
        s1_valid_r <= accept_s;
        if (accept_s) begin
          s1_chan_r  <= bus.in_chan;
          s1_coord_r <= bus.in_coord;
          s1_off_r   <= off_rd_s;
          s1_sign_r  <= bus.in_coord < off_rd_s;
          s1_zero_r  <= bus.in_coord == off_rd_s;
        end
      end
      if (s2_free_s) begin
        s2_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          out_r <= '{chan: s1_chan_r, mag: mag_s, sign: s1_sign_r,
                     zero: s1_zero_r, clamped: clamped_s};
        end
      end
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = s2_valid_r;
  assign bus.out_chan    = out_r.chan;
  assign bus.out_mag     = out_r.mag;
  assign bus.out_sign    = out_r.sign;
  assign bus.out_zero    = out_r.zero;
  assign bus.out_clamped = out_r.clamped;
endmodule

// File: tb/tb_sign_deduction_pipe.sv
// Bench for sign_deduction_pipe: an unclamped and a CLAMP=20 instance share one stimulus
// stream; a queue-based model predicts every result, plus directed literal expectations.
module tb_sign_deduction_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        off_we = 1'b0;
  logic        off_sel = 1'b0;
  logic [11:0] off_data = 12'd0;
  logic        in_valid = 1'b0;
  logic        in_chan = 1'b0;
  logic [11:0] in_coord = 12'd0;
  logic        in_cal = 1'b0;
  logic        out_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sign_deduction_pipe_if #(.WIDTH(12), .CW(1)) ifa ();
  sign_deduction_pipe_if #(.WIDTH(12), .CW(1)) ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_chan   = in_chan;
  assign ifa.in_coord  = in_coord;
  assign ifa.in_cal    = in_cal;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_chan   = in_chan;
  assign ifb.in_coord  = in_coord;
  assign ifb.in_cal    = in_cal;
  assign ifb.out_ready = out_ready;

  sign_deduction_pipe #(.WIDTH(12), .CHANNELS(2), .CLAMP(0)) dut_a (
    .clk(clk), .rst(rst), .off_we(off_we), .off_sel(off_sel), .off_data(off_data), .bus(ifa)
  );

  sign_deduction_pipe #(.WIDTH(12), .CHANNELS(2), .CLAMP(20)) dut_b (
    .clk(clk), .rst(rst), .off_we(off_we), .off_sel(off_sel), .off_data(off_data), .bus(ifb)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: results queued at acceptance; a result is visible two cycles
  // after acceptance, or one cycle after its predecessor leaves, whichever is later.
  typedef struct {
    int          acc;
    logic        chan;
    logic [11:0] mag_a;
    logic [11:0] mag_b;
    logic        sign;
    logic        zero;
    logic        clamp_b;
  } exp_t;

  exp_t q[$];
  int   mo[2] = '{0, 0};
  int   cyc = 0;
  int   last_leave = -10;
  bit   chk_en = 1'b0;

  always @(negedge clk) begin
    logic exp_ready;
    logic exp_valid;
    int   vis;
    int   diff;
    int   off;
    exp_t e;
    if (chk_en) begin
      cyc++;
      exp_ready = (q.size() < 2) || out_ready;
      check("in_ready_a", ifa.in_ready, exp_ready);
      check("in_ready_b", ifb.in_ready, exp_ready);
      exp_valid = 1'b0;
      if (q.size() > 0) begin
        vis = q[0].acc + 2;
        if (last_leave + 1 > vis) vis = last_leave + 1;
        exp_valid = (cyc >= vis);
      end
      check("out_valid_a", ifa.out_valid, exp_valid);
      check("out_valid_b", ifb.out_valid, exp_valid);
      if (exp_valid) begin
        check("chan_a", ifa.out_chan, q[0].chan);
        check("mag_a", ifa.out_mag, q[0].mag_a);
        check("sign_a", ifa.out_sign, q[0].sign);
        check("zero_a", ifa.out_zero, q[0].zero);
        check("clamped_a", ifa.out_clamped, 0);
        check("chan_b", ifb.out_chan, q[0].chan);
        check("mag_b", ifb.out_mag, q[0].mag_b);
        check("sign_b", ifb.out_sign, q[0].sign);
        check("zero_b", ifb.out_zero, q[0].zero);
        check("clamped_b", ifb.out_clamped, q[0].clamp_b);
      end
      if (rst) begin
        q.delete();
        mo = '{0, 0};
        last_leave = -10;
      end else begin
        if (exp_valid && out_ready) begin
          void'(q.pop_front());
          last_leave = cyc;
        end
        if (in_valid && exp_ready) begin
          off       = mo[in_chan];
          diff      = (int'(in_coord) < off) ? off - int'(in_coord) : int'(in_coord) - off;
          e.acc     = cyc;
          e.chan    = in_chan;
          e.sign    = int'(in_coord) < off;
          e.zero    = int'(in_coord) == off;
          e.mag_a   = 12'(diff);
          e.mag_b   = (diff > 20) ? 12'd20 : 12'(diff);
          e.clamp_b = diff > 20;
          q.push_back(e);
          if (in_cal) mo[in_chan] = int'(in_coord);
        end
        if (off_we) mo[off_sel] = int'(off_data);
      end
    end
  end

  initial begin
    int k;
    int stalls;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", ifa.out_valid, 0);
    check("rst_out_mag", ifa.out_mag, 0);
    check("rst_out_chan", ifa.out_chan, 0);
    check("rst_out_sign", ifa.out_sign, 0);
    check("rst_out_zero", ifa.out_zero, 0);
    check("rst_out_clamped", ifb.out_clamped, 0);
    check("rst_in_ready", ifa.in_ready, 1);
    tick();

    // offset[0] = 48, coord 40
    off_we = 1'b1; off_sel = 1'b0; off_data = 12'd48;
    tick();
    off_we = 1'b0; in_valid = 1'b1; in_chan = 1'b0; in_coord = 12'd40;
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    check("t1_valid", ifa.out_valid, 1);
    check("t1_mag", ifa.out_mag, 8);
    check("t1_sign", ifa.out_sign, 1);
    check("t1_zero", ifa.out_zero, 0);
    tick();

    // calibration on ch1 uses the old offset; the next sample sees the new one
    in_valid = 1'b1; in_chan = 1'b1; in_coord = 12'd100; in_cal = 1'b1;
    tick();
    in_coord = 12'd95; in_cal = 1'b0;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("t2_mag0", ifa.out_mag, 100);
    check("t2_sign0", ifa.out_sign, 0);
    tick();
    @(negedge clk);
    check("t2_mag1", ifa.out_mag, 5);
    check("t2_sign1", ifa.out_sign, 1);
    tick();

    // clamp instance, offset[0] = 10
    off_we = 1'b1; off_sel = 1'b0; off_data = 12'd10;
    tick();
    off_we = 1'b0; in_valid = 1'b1; in_chan = 1'b0; in_coord = 12'd4095;
    tick();
    in_coord = 12'd30;
    tick();
    in_coord = 12'd10;
    @(negedge clk);
    check("t3_mag_b0", ifb.out_mag, 20);
    check("t3_clamped_b0", ifb.out_clamped, 1);
    check("t3_mag_a0", ifa.out_mag, 4085);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("t3_mag_b1", ifb.out_mag, 20);
    check("t3_clamped_b1", ifb.out_clamped, 0);
    tick();
    @(negedge clk);
    check("t3_zero_b2", ifb.out_zero, 1);
    check("t3_mag_b2", ifb.out_mag, 0);
    tick();

    // 8-sample stream with out_ready low for 5 cycles
    k = 0;
    stalls = 0;
    for (int s = 0; s < 40 && k < 8; s++) begin
      in_valid  = 1'b1;
      in_chan   = k[0];
      in_coord  = 12'(200 + k * 3);
      out_ready = !(s >= 3 && s <= 7);
      @(negedge clk);
      if (ifa.in_ready) k++;
      else stalls++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_accepted", k, 8);
    check("stream_stalls", stalls, 5);
    repeat (4) tick();

    // direct write and calibration collide on ch0 (old offset is 10)
    off_we = 1'b1; off_sel = 1'b0; off_data = 12'd7;
    in_valid = 1'b1; in_chan = 1'b0; in_coord = 12'd300; in_cal = 1'b1;
    tick();
    off_we = 1'b0; in_cal = 1'b0; in_coord = 12'd7;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_mag0", ifa.out_mag, 290);
    check("t5_sign0", ifa.out_sign, 0);
    tick();
    @(negedge clk);
    check("t5_zero1", ifa.out_zero, 1);
    check("t5_mag1", ifa.out_mag, 0);
    tick();

    // reset with two samples in flight
    out_ready = 1'b0;
    in_valid = 1'b1; in_chan = 1'b0; in_coord = 12'd50;
    tick();
    in_chan = 1'b1; in_coord = 12'd60;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_chan = 1'b0; in_coord = 12'd0;
    @(negedge clk);
    check("t6_valid_a", ifa.out_valid, 0);
    check("t6_valid_b", ifb.out_valid, 0);
    tick();
    in_chan = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("t6_mag0", ifa.out_mag, 0);
    check("t6_zero0", ifa.out_zero, 1);
    tick();
    @(negedge clk);
    check("t6_zero1", ifa.out_zero, 1);
    check("t6_chan1", ifa.out_chan, 1);
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      in_chan   = 1'($urandom_range(0, 1));
      in_coord  = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095))
                                              : 12'($urandom_range(0, 60));
      in_cal    = $urandom_range(0, 9) == 0;
      off_we    = $urandom_range(0, 9) == 0;
      off_sel   = 1'($urandom_range(0, 1));
      off_data  = 12'($urandom_range(0, 60));
      out_ready = $urandom_range(0, 9) < 7;
      rst       = $urandom_range(0, 299) == 0;
      tick();
    end
    in_valid = 1'b0; in_cal = 1'b0; off_we = 1'b0; rst = 1'b0; out_ready = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    check("drain_empty", q.size(), 0);
    check("drain_valid", ifa.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sign_deduction_pipe.md
# sign_deduction_pipe

Multi-channel, pipelined successor to the combinational sign/magnitude stage. It holds one programmable offset per channel and accepts coordinate samples over a valid/ready handshake. For each sample it emits the magnitude |coord − offset|, a sign flag, and zero/clamp flags two cycles later. It sits between coordinate producers (sensor/cursor logic) and the OLED/drawing path, and also supports in-band centre calibration.

## Interface
- WIDTH, 12, bit width of coordinates, offsets and magnitude
- CHANNELS, 2, number of independent offset channels (≥1)
- CLAMP, 0, saturation limit for magnitude; 0 disables clamping
- CW (localparam), max(1, $clog2(CHANNELS)), channel index width
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- off_we  in  1  direct offset write strobe
- off_sel  in  CW  channel written by off_we
- off_data  in  WIDTH  offset value for off_we
- in_valid  in  1  sample present
- in_ready  out  1  block can accept a sample this cycle
- in_chan  in  CW  channel of the sample
- in_coord  in  WIDTH  unsigned coordinate
- in_cal  in  1  with an accepted sample: load in_coord as the new offset of in_chan
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- out_chan  out  CW  channel of the result
- out_mag  out  WIDTH  |coord − offset|, clamped if enabled
- out_sign  out  1  1 when coord < offset, else 0
- out_zero  out  1  1 when coord == offset
- out_clamped  out  1  1 when magnitude exceeded CLAMP and was saturated

## Operation
- Offset registers: CHANNELS × WIDTH, all 0 after reset.
- A sample is accepted when in_valid && in_ready.
- Stage 1 (capture):
  - On accept, register coord, chan, and the offset of in_chan as read this cycle (old value).
  - Register the comparison flag coord < offset and the equality flag.
- Stage 2 (compute):
  - mag = sign ? offset − coord : coord − offset. This is exact in WIDTH bits, with no overflow.
  - If CLAMP != 0 and mag > CLAMP: out_mag = CLAMP, out_clamped = 1. Otherwise out_clamped = 0.
- Offset updates:
  - Direct write: off_we writes off_data to offset[off_sel].
  - Calibration: an accepted sample with in_cal writes in_coord to offset[in_chan]. That sample itself still uses the old offset.
  - Collision (off_we and a calibration hit the same channel in the same cycle): off_we wins.
  - An update is visible to samples accepted in the next cycle or later, never to samples already in flight.
- Out-of-range channel indices (in_chan or off_sel ≥ CHANNELS) when CHANNELS is not a power of two:
  - Such a sample is accepted and passed through with offset 0.
  - Writes to such an index are ignored.
- Elastic pipeline:
  - Each stage has its own valid bit.
  - A stage advances when the stage downstream of it is empty or is being drained this cycle.
  - in_ready = !s1_valid || (!s2_valid || out_ready). This is a combinational path from out_ready.

## Timing
- Reset values:
  - in_ready = 1 during the cycle after reset.
  - out_valid, out_chan, out_mag, out_sign, out_zero, out_clamped = 0.
  - Both stage valid bits and all offsets = 0.
- Latency: an accepted sample appears on out_valid 2 cycles later when out_ready is held high.
- Throughput: 1 sample per cycle with no bubbles.
- Backpressure:
  - While out_valid && !out_ready, all out_* signals hold stable.
  - Stage 1 can still fill. After that, in_ready = 0.
  - No sample may be dropped or duplicated.
- Reset mid-operation: in-flight samples are discarded, offsets return to 0, and out_valid drops the cycle after rst is sampled.
- Simultaneous drain and accept with the pipeline full: both occur in the same cycle.

## Structure
- Shared package: sign/magnitude result typedef {chan, mag, sign, zero, clamped} and the clamp-disable constant 0.
- One natural sub-module: sign_mag_core (combinational stage-2 subtract/clamp).
- Offset register file, calibration muxing and handshake logic stay in the top level.

## Test plan
- Reset, then write offset[0] = 48, then sample ch0 coord = 40 → out_mag = 8, out_sign = 1, out_zero = 0, 2 cycles after accept.
- Sample ch1 coord = 100, in_cal = 1 (offset 0), then ch1 coord = 95 → first result mag 100 sign 0; second result mag 5 sign 1.
- CLAMP = 20, offset[0] = 10, coord = 4095 → out_mag = 20, out_clamped = 1; coord = 30 → mag 20, clamped 0; coord = 10 → out_zero = 1.
- Stream 8 back-to-back samples with out_ready low for 5 cycles mid-stream → in_ready drops after 2 stalled entries; all 8 results emerge in order with stable outputs while stalled.
- off_we (ch0 = 7) and calibration sample (ch0 coord = 300) in the same cycle → offset[0] = 7; that sample uses the old offset.
- Assert rst with 2 samples in flight → out_valid = 0 next cycle, offsets read back 0 via a coord = 0 sample (mag 0, zero 1).
